register_file_rb: RTL

REGISTER_FILE_RB -- requirements
Module: register_file_rb

---
 rtl/register_file_rb_if.sv | 20 ++
 rtl/register_file_rb.sv | 66 ++++++
 2 files changed

// File: rtl/register_file_rb_if.sv
// register_file_rb_if -- bus bundle for the posted-write register file.
//   master : drives enable, wr_sel, BusMuxOut, rd_sel, BAout; samples BusMuxIn, stall
//   slave  : the register file itself
interface register_file_rb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic              enable;     // write request
  logic [ADDR_W-1:0] wr_sel;     // write index
  logic [WIDTH-1:0]  BusMuxOut;  // write data
  logic [ADDR_W-1:0] rd_sel;     // read index
  logic              BAout;      // zero-force for register 0 reads
  logic [WIDTH-1:0]  BusMuxIn;   // read data
  logic              stall;      // read hits a not-yet-committed write

  modport master (output enable, wr_sel, BusMuxOut, rd_sel, BAout,
                  input  BusMuxIn, stall);
  modport slave  (input  enable, wr_sel, BusMuxOut, rd_sel, BAout,
                  output BusMuxIn, stall);
endinterface

// File: rtl/register_file_rb.sv
// register_file_rb -- DEPTH x WIDTH register file with a one-entry posted
// write buffer. A write is captured at one edge and committed to the array at
// the next, so a new write can be accepted every cycle.
// Ports:
//   clk  : rising-edge clock
//   clr  : synchronous active-high reset; zeroes array and drops pending write
//   bus  : register_file_rb_if.slave (write request, read port, stall)
// Build option:
//   REGFILE_BYPASS_EN defined   -> read hitting the pending entry returns the
//                                  pending data, stall=0
//   REGFILE_BYPASS_EN undefined -> such a read returns the stale array value
//                                  and raises stall until the commit
module register_file_rb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  register_file_rb_if.slave bus
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                        pend_valid_q;
  logic [ADDR_W-1:0]           pend_addr_q;
  logic [WIDTH-1:0]            pend_data_q;

  // clr wins over both the commit and a same-edge capture.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      // Commit the old entry and capture the new one on the same edge; the
      // buffer is never full when a request arrives.
      if (pend_valid_q) mem_q[pend_addr_q] <= pend_data_q;
      pend_valid_q <= bus.enable;
      if (bus.enable) begin
        pend_addr_q <= bus.wr_sel;
        pend_data_q <= bus.BusMuxOut;
      end
    end
  end

  logic pend_hit;
  logic ba_zero;
  assign pend_hit = pend_valid_q && (pend_addr_q == bus.rd_sel);
  assign ba_zero  = bus.BAout && (bus.rd_sel == '0);

  always_comb begin
    bus.BusMuxIn = mem_q[bus.rd_sel];
    bus.stall    = 1'b0;
    if (ba_zero) begin
      bus.BusMuxIn = '0;
    end else if (pend_hit) begin
`ifdef REGFILE_BYPASS_EN
      bus.BusMuxIn = pend_data_q;
`else
      bus.stall    = 1'b1;
`endif
    end
  end

endmodule
